bcd_updown_counter_n: RTL and testbench
=======================================

// Module: bcd_updown_counter_n
// PURPOSE
//   Multi-digit cascaded BCD up/down counter with built-in input synchroniser
//   and single-pulser on the up/down button inputs. Generalises the one-digit
//   counter + external single-pulser pair to DIGITS digits in one block.
//   Sits between raw push-button inputs and the 7-segment display driver.
// PARAMETERS
//   DIGITS       4   number of BCD digits (1..8); digit 0 = least significant
//   SYNC_STAGES  2   flip-flop synchroniser depth on up/down (>=1)
// PORTS
//   clk      in   1          system clock, all state on rising edge
//   reset    in   1          asynchronous, active-high; clears all state
//   up       in   1          raw up button (async, level; one count per press)
//   down     in   1          raw down button (async, level; one count per press)
//   set9     in   1          synchronous level: load all digits to 9
//   set0     in   1          synchronous level: load all digits to 0
//   outputs  out  4*DIGITS   BCD value, digit i at [4*i+3:4*i]
//   cout     out  1          1-cycle pulse: increment wrapped all-9s -> all-0s
//   bout     out  1          1-cycle pulse: decrement wrapped all-0s -> all-9s
// BEHAVIOUR
//   - Reset (async assert, sync use): outputs=0, cout=0, bout=0,
//     synchroniser and pulser history regs=0. Mid-operation reset aborts any
//     pending pulse; a button held through reset release produces no count
//     until released and pressed again.
//   - up/down each pass through SYNC_STAGES flops, then rising-edge detect
//     (pulse = sync & ~sync_d). Held button = exactly one count.
//   - Latency: count updates on the (SYNC_STAGES+1)th rising clk edge after
//     up/down is first sampled high.
//   - Priority per cycle: set0 > set9 > (up_p & down_p: no change) >
//     up_p > down_p. set0/set9 do not suppress pulse detection; a pulse
//     coinciding with set is discarded.
//   - Increment: digit 0 +1; digit i rolls 9->0 and carries to digit i+1.
//     Decrement: digit 0 -1; digit i rolls 0->9 and borrows from digit i+1.
//   - cout/bout registered, asserted in the same cycle outputs shows the
//     wrapped value; deasserted next cycle. Never asserted by set0/set9.
//   - Digit values 10..15 are unreachable (only reset/set/count write them).
// CONFIGURATION
//   BCD_SATURATE_EN defined: counting saturates; up at all-9s and down at
//     all-0s leave outputs unchanged and still pulse cout/bout (overflow
//     attempt indicator).
//   BCD_SATURATE_EN undefined (default): wrap-around as described above.
// TESTING (DIGITS=4, SYNC_STAGES=2, wrap mode unless noted)
//   1 reset high 3 cycles, release -> outputs=16'h0000, cout=bout=0.
//   2 12 up presses (each held 5 cycles, gap 5) -> outputs=16'h0012; one
//     press held 50 cycles -> only +1; update on 3rd edge after sampling.
//   3 set9 1 cycle, then 1 up press -> outputs 16'h9999 then 16'h0000,
//     cout=1 for exactly that cycle; bout=0.
//   4 set0, then 1 down press -> outputs=16'h9999, bout pulse 1 cycle;
//     further press -> 16'h9998.
//   5 up and down pulses same cycle -> no change; set0 and set9 together
//     with up pulse -> 16'h0000, no cout.
//   6 BCD_SATURATE_EN: at 16'h9999 press up -> stays 16'h9999, cout pulse;
//     reset asserted mid-press -> 16'h0000, no count after release.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with button synchronisers and single-pulsers.
// Define BCD_SATURATE_EN to make counting saturate instead of wrapping.
module bcd_updown_counter_n #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up,
    input  logic                  down,
    input  logic                  set9,
    input  logic                  set0,
    output logic [4*DIGITS-1:0]   outputs,
    output logic                  cout,
    output logic                  bout
);

    localparam int W = 4 * DIGITS;

    logic [SYNC_STAGES-1:0] up_sync;
    logic [SYNC_STAGES-1:0] down_sync;
    logic [SYNC_STAGES-1:0] primed;
    logic                   up_d;
    logic                   down_d;
    logic                   up_arm;
    logic                   down_arm;
    logic                   up_s;
    logic                   down_s;
    logic                   up_p;
    logic                   down_p;
    logic                   all9;
    logic                   all0;
    logic [W-1:0]           cnt_nxt;
    logic                   cout_nxt;
    logic                   bout_nxt;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign up_s   = up_sync[SYNC_STAGES-1];
    assign down_s = down_sync[SYNC_STAGES-1];

    // A button only arms once it has been seen released after reset.
    assign up_p   = up_s & ~up_d & up_arm;
    assign down_p = down_s & ~down_d & down_arm;

    assign all9 = (outputs == {DIGITS{4'h9}});
    assign all0 = (outputs == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_sync   <= '0;
            down_sync <= '0;
            primed    <= '0;
            up_d      <= 1'b0;
            down_d    <= 1'b0;
            up_arm    <= 1'b0;
            down_arm  <= 1'b0;
        end else begin
            up_sync   <= SYNC_STAGES'({up_sync, up});
            down_sync <= SYNC_STAGES'({down_sync, down});
            primed    <= SYNC_STAGES'({primed, 1'b1});
            up_d      <= up_s;
            down_d    <= down_s;
            up_arm    <= up_arm | (primed[SYNC_STAGES-1] & ~up_s);
            down_arm  <= down_arm | (primed[SYNC_STAGES-1] & ~down_s);
        end
    end

    always_comb begin
        cnt_nxt  = outputs;
        cout_nxt = 1'b0;
        bout_nxt = 1'b0;
        if (set0) begin
            cnt_nxt = '0;
        end else if (set9) begin
            cnt_nxt = {DIGITS{4'h9}};
        end else if (up_p && down_p) begin
            cnt_nxt = outputs;
        end else if (up_p) begin
            if (all9) begin
                cout_nxt = 1'b1;
`ifdef BCD_SATURATE_EN
                cnt_nxt  = outputs;
`else
                cnt_nxt  = '0;
`endif
            end else begin
                cnt_nxt = bcd_inc(outputs);
            end
        end else if (down_p) begin
            if (all0) begin
                bout_nxt = 1'b1;
`ifdef BCD_SATURATE_EN
                cnt_nxt  = outputs;
`else
                cnt_nxt  = {DIGITS{4'h9}};
`endif
            end else begin
                cnt_nxt = bcd_dec(outputs);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outputs <= '0;
            cout    <= 1'b0;
            bout    <= 1'b0;
        end else begin
            outputs <= cnt_nxt;
            cout    <= cout_nxt;
            bout    <= bout_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n (DIGITS=4, SYNC_STAGES=2).
module tb_bcd_updown_counter_n;

    typedef struct {
        logic [15:0] v;
        logic        c;
        logic        b;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        up;
    logic        down;
    logic        set9;
    logic        set0;
    logic [15:0] outputs;
    logic        cout;
    logic        bout;

    exp_t        sb[$];
    int          total;
    int          bad;
    bit          mon_en;
    logic [15:0] prev;

    bcd_updown_counter_n #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .up      (up),
        .down    (down),
        .set9    (set9),
        .set0    (set0),
        .outputs (outputs),
        .cout    (cout),
        .bout    (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd4(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    task automatic expect_ev(input logic [15:0] v, input logic c, input logic b);
        exp_t e;
        e.v = v;
        e.c = c;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic press(input logic u, input logic d, input int hold);
        @(posedge clk);
        #1 up = u;
        down = d;
        repeat (hold) @(posedge clk);
        #1 up = 1'b0;
        down = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic check(input string name, input logic [17:0] act,
                         input logic [17:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: any value change or flag pulse is an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (outputs !== prev || cout !== 1'b0 || bout !== 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got out=%h cout=%b bout=%b want none",
                             outputs, cout, bout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (outputs !== e.v || cout !== e.c || bout !== e.b) begin
                        bad++;
                        $display("FAIL event: got out=%h cout=%b bout=%b want out=%h cout=%b bout=%b",
                                 outputs, cout, bout, e.v, e.c, e.b);
                    end
                end
            end
            prev = outputs;
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        prev   = '0;
        reset  = 1'b1;
        up     = 1'b0;
        down   = 1'b0;
        set9   = 1'b0;
        set0   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out", {2'b00, outputs}, 18'h0);
        check("reset_cout", {17'h0, cout}, 18'h0);
        check("reset_bout", {17'h0, bout}, 18'h0);
        prev   = outputs;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 1; i <= 12; i++) begin
            expect_ev(bcd4(i), 1'b0, 1'b0);
            press(1'b1, 1'b0, 5);
        end

        // Long press: exactly one count, landing on the third edge.
        expect_ev(16'h0013, 1'b0, 1'b0);
        @(posedge clk);
        #1 up = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("latency_edge2", {2'b00, outputs}, {2'b00, 16'h0012});
        @(posedge clk);
        #1 check("latency_edge3", {2'b00, outputs}, {2'b00, 16'h0013});
        repeat (47) @(posedge clk);
        #1 up = 1'b0;
        repeat (5) @(posedge clk);

        expect_ev(16'h9999, 1'b0, 1'b0);
        @(posedge clk);
        #1 set9 = 1'b1;
        @(posedge clk);
        #1 set9 = 1'b0;
        expect_ev(16'h0000, 1'b1, 1'b0);
        press(1'b1, 1'b0, 5);

        @(posedge clk);
        #1 set0 = 1'b1;
        @(posedge clk);
        #1 set0 = 1'b0;
        expect_ev(16'h9999, 1'b0, 1'b1);
        press(1'b0, 1'b1, 5);
        expect_ev(16'h9998, 1'b0, 1'b0);
        press(1'b0, 1'b1, 5);

        press(1'b1, 1'b1, 5);

        // Up pulse under simultaneous set0/set9 is swallowed.
        expect_ev(16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 set0 = 1'b1;
        set9 = 1'b1;
        press(1'b1, 1'b0, 5);
        @(posedge clk);
        #1 set0 = 1'b0;
        set9 = 1'b0;
        repeat (3) @(posedge clk);
        expect_ev(16'h0001, 1'b0, 1'b0);
        press(1'b1, 1'b0, 5);

        expect_ev(16'h9999, 1'b0, 1'b0);
        @(posedge clk);
        #1 set9 = 1'b1;
        @(posedge clk);
        #1 set9 = 1'b0;
`ifdef BCD_SATURATE_EN
        expect_ev(16'h9999, 1'b1, 1'b0);
        press(1'b1, 1'b0, 5);
`else
        expect_ev(16'h0000, 1'b1, 1'b0);
        press(1'b1, 1'b0, 5);
        expect_ev(16'h0001, 1'b0, 1'b0);
        press(1'b1, 1'b0, 5);
`endif

        // Reset mid-press with the button held through release.
        expect_ev(16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 up = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1 up = 1'b0;
        repeat (10) @(posedge clk);
        expect_ev(16'h0001, 1'b0, 1'b0);
        press(1'b1, 1'b0, 5);

        repeat (10) @(posedge clk);
        check("sb_drained", 18'(sb.size()), 18'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
